// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the counter-width helper.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_SUM = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_RSV = 3'b110
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ITER   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned core: shift-add multiply and restoring divide, one step per i_step.
// Results: multiply {o_hi, o_lo} = product; divide o_lo = quotient, o_hi = remainder.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_last
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [CntW-1:0]  r_cnt;
  logic             r_div;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;

  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shl  = {r_hi, r_lo[WIDTH-1]};
    // Extra guard bit so the trial subtraction's sign is never lost.
    w_diff = {1'b0, w_shl} - {2'b00, r_b};
    w_neg  = w_diff[WIDTH+1];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (i_start) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_div <= i_div;
      r_cnt <= CntW'(WIDTH);
    end else if (i_step) begin
      r_cnt <= r_cnt - CntW'(1);
      if (r_div) begin
        r_hi <= w_neg ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], ~w_neg};
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_lo   = r_lo;
  assign o_hi   = r_hi;
  assign o_last = (r_cnt == CntW'(1));

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with operand registers and START/BUSY/DONE handshake.
// Optional signed arithmetic is enabled by defining SEQ_ALU_SIGNED_EN.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             An,
  input  logic             Bn,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       OP,
  input  logic             START,
`ifdef SEQ_ALU_SIGNED_EN
  input  logic             SIGNED,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Dout,
  output logic [WIDTH-1:0] DoutH,
  output logic             CARRY,
  output logic             DIVZ
);

  localparam int unsigned     Msb  = WIDTH - 1;
  localparam logic [WIDTH-1:0] WVal = WIDTH'(WIDTH);

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_a, r_b, r_opa, r_opb;
  logic [WIDTH-1:0] r_dout, r_douth;
  logic             r_sgn, r_nega, r_negq;
  logic             r_busy, r_done, r_carry, r_divz;

  logic             w_signed, w_start, w_last;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_md_lo, w_md_hi;
  logic [WIDTH-1:0] w_lo, w_hi;
  logic             w_carry, w_divz;
  logic [WIDTH:0]   w_sum, w_dif;
  logic [2*WIDTH-1:0] w_prod;

`ifdef SEQ_ALU_SIGNED_EN
  assign w_signed = SIGNED;
`else
  assign w_signed = 1'b0;
`endif

  assign w_start = (r_state == S_IDLE) && START && !r_done;
  // The core always works on magnitudes; signs are restored in FINISH.
  assign w_mag_a = (w_signed && r_a[Msb]) ? -r_a : r_a;
  assign w_mag_b = (w_signed && r_b[Msb]) ? -r_b : r_b;

  seq_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_start(w_start),
    .i_step (r_state == S_ITER),
    .i_div  (OP == OP_DIV),
    .i_a    (w_mag_a),
    .i_b    (w_mag_b),
    .o_lo   (w_md_lo),
    .o_hi   (w_md_hi),
    .o_last (w_last)
  );

  assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
  assign w_dif  = {1'b0, r_opa} - {1'b0, r_opb};
  assign w_prod = {w_md_hi, w_md_lo};

  always_comb begin
    w_lo    = '0;
    w_hi    = '0;
    w_carry = 1'b0;
    w_divz  = 1'b0;
    case (r_op)
      OP_SUM: begin
        w_lo    = w_sum[WIDTH-1:0];
        w_carry = r_sgn ? ((r_opa[Msb] == r_opb[Msb]) && (w_sum[Msb] != r_opa[Msb]))
                        : w_sum[WIDTH];
      end
      OP_SUB: begin
        w_lo    = w_dif[WIDTH-1:0];
        w_carry = r_sgn ? ((r_opa[Msb] != r_opb[Msb]) && (w_dif[Msb] != r_opa[Msb]))
                        : w_dif[WIDTH];
      end
      OP_MUL: {w_hi, w_lo} = r_negq ? -w_prod : w_prod;
      OP_DIV: begin
        if (r_opb == '0) begin
          w_lo   = '1;
          w_hi   = r_opa;
          w_divz = 1'b1;
        end else begin
          w_lo = r_negq ? -w_md_lo : w_md_lo;
          w_hi = r_nega ? -w_md_hi : w_md_hi;
        end
      end
      OP_SHL: w_lo = (r_opb >= WVal) ? '0 : r_opa << r_opb;
      OP_SHR: begin
        if (r_sgn) w_lo = $unsigned($signed(r_opa) >>> r_opb);
        else       w_lo = (r_opb >= WVal) ? '0 : r_opa >> r_opb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_op    <= OP_SUM;
      r_a     <= '0;
      r_b     <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sgn   <= 1'b0;
      r_nega  <= 1'b0;
      r_negq  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
      r_douth <= '0;
      r_carry <= 1'b0;
      r_divz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!An) r_a <= Din;
          if (!Bn) r_b <= Din;
          if (w_start) begin
            r_op   <= op_e'(OP);
            r_opa  <= r_a;
            r_opb  <= r_b;
            r_sgn  <= w_signed;
            r_nega <= w_signed & r_a[Msb];
            r_negq <= w_signed & (r_a[Msb] ^ r_b[Msb]);
            if (OP == OP_MUL || (OP == OP_DIV && r_b != '0)) r_state <= S_ITER;
            else                                             r_state <= S_FINISH;
          end
        end
        S_ITER: begin
          r_busy <= 1'b1;
          if (w_last) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dout  <= w_lo;
          r_douth <= w_hi;
          r_carry <= w_carry;
          r_divz  <= w_divz;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY  = r_busy;
  assign DONE  = r_done;
  assign Dout  = r_dout;
  assign DoutH = r_douth;
  assign CARRY = r_carry;
  assign DIVZ  = r_divz;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         An, Bn, START;
  logic [W-1:0] Din;
  logic [2:0]   OP;
  logic         BUSY, DONE, CARRY, DIVZ;
  logic [W-1:0] Dout, DoutH;
`ifdef SEQ_ALU_SIGNED_EN
  logic         sgn;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  seq_alu #(
    .WIDTH(W)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .An   (An),
    .Bn   (Bn),
    .Din  (Din),
    .OP   (OP),
    .START(START),
`ifdef SEQ_ALU_SIGNED_EN
    .SIGNED(sgn),
`endif
    .BUSY (BUSY),
    .DONE (DONE),
    .Dout (Dout),
    .DoutH(DoutH),
    .CARRY(CARRY),
    .DIVZ (DIVZ)
  );

  task automatic load_a(input logic [W-1:0] v);
    Din = v; An = 1'b0;
    @(posedge CLK); #1;
    An = 1'b1;
  endtask

  task automatic load_b(input logic [W-1:0] v);
    Din = v; Bn = 1'b0;
    @(posedge CLK); #1;
    Bn = 1'b1;
  endtask

  // Issues one op and waits (bounded) for DONE; lat = edges after the START edge, -1 on timeout.
  // With inject set, a load of A and a second START are attempted mid-operation.
  task automatic run_op(input logic [2:0] op, input bit inject, output int lat, output int bc);
    @(posedge CLK); #1;
    OP = op; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 0;
    bc  = 0;
    while (lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (DONE) break;
      if (BUSY) bc++;
      if (inject && lat == 3) begin
        Din = 8'h00; An = 1'b0; OP = 3'b001; START = 1'b1;
      end
      if (inject && lat == 4) begin
        An = 1'b1; START = 1'b0;
      end
    end
    if (!DONE) lat = -1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", DONE); end
    checks++; if (Dout !== 8'h00) begin failures++; $display("FAIL reset_dout got %h want 00", Dout); end
    checks++; if ({DoutH, CARRY, DIVZ} !== 10'h000) begin
      failures++; $display("FAIL reset_flags got %h want 000", {DoutH, CARRY, DIVZ});
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_sum_sub();
    int lat, bc;
    load_a(8'h07); load_b(8'h06);
    run_op(3'b000, 1'b0, lat, bc);
    checks++; if (lat !== 1) begin failures++; $display("FAIL sum_latency got %0d want 1", lat); end
    checks++; if (Dout !== 8'h0D) begin failures++; $display("FAIL sum_dout got %h want 0d", Dout); end
    checks++; if (CARRY !== 1'b0) begin failures++; $display("FAIL sum_carry got %b want 0", CARRY); end
    @(posedge CLK); #1;
    checks++; if ({DONE, Dout} !== 9'h00D) begin
      failures++; $display("FAIL done_pulse_hold got %h want 00d", {DONE, Dout});
    end
    load_a(8'h04); load_b(8'h05);
    run_op(3'b001, 1'b0, lat, bc);
    checks++; if (Dout !== 8'hFF) begin failures++; $display("FAIL sub_dout got %h want ff", Dout); end
    checks++; if ({CARRY, DoutH} !== 9'h100) begin
      failures++; $display("FAIL sub_borrow got %h want 100", {CARRY, DoutH});
    end
    load_a(8'hFF); load_b(8'h01);
    run_op(3'b000, 1'b0, lat, bc);
    checks++; if ({CARRY, Dout} !== 9'h100) begin
      failures++; $display("FAIL sum_wrap got %h want 100", {CARRY, Dout});
    end
  endtask

  task automatic test_mul();
    int lat, bc;
    load_a(8'hFF); load_b(8'hFF);
    run_op(3'b010, 1'b1, lat, bc);
    checks++; if (lat !== 9) begin failures++; $display("FAIL mul_latency got %0d want 9", lat); end
    checks++; if (bc !== 8) begin failures++; $display("FAIL mul_busy_cycles got %0d want 8", bc); end
    checks++; if ({DoutH, Dout} !== 16'hFE01) begin
      failures++; $display("FAIL mul_result got %h want fe01", {DoutH, Dout});
    end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL mul_busy_at_done got %b want 0", BUSY); end
    run_op(3'b010, 1'b0, lat, bc);
    checks++; if ({DoutH, Dout} !== 16'hFE01) begin
      failures++; $display("FAIL mul_rerun got %h want fe01", {DoutH, Dout});
    end
  endtask

  task automatic test_div();
    int lat, bc;
    load_a(8'h64); load_b(8'h07);
    run_op(3'b011, 1'b0, lat, bc);
    checks++; if (lat !== 9) begin failures++; $display("FAIL div_latency got %0d want 9", lat); end
    checks++; if ({DoutH, Dout, DIVZ} !== 17'h0041C) begin
      failures++; $display("FAIL div_result got %h want 0041c", {DoutH, Dout, DIVZ});
    end
    load_b(8'h00);
    run_op(3'b011, 1'b0, lat, bc);
    checks++; if (lat !== 1) begin failures++; $display("FAIL divz_latency got %0d want 1", lat); end
    checks++; if ({DIVZ, Dout, DoutH} !== 17'h1FF64) begin
      failures++; $display("FAIL divz_result got %h want 1ff64", {DIVZ, Dout, DoutH});
    end
  endtask

  task automatic test_shift();
    int lat, bc;
    load_a(8'h08); load_b(8'h02);
    run_op(3'b101, 1'b0, lat, bc);
    checks++; if ({DIVZ, Dout} !== 9'h002) begin
      failures++; $display("FAIL shr_clears_divz got %h want 002", {DIVZ, Dout});
    end
    run_op(3'b100, 1'b0, lat, bc);
    checks++; if (Dout !== 8'h20) begin failures++; $display("FAIL shl got %h want 20", Dout); end
    load_b(8'h09);
    run_op(3'b100, 1'b0, lat, bc);
    checks++; if (Dout !== 8'h00) begin failures++; $display("FAIL shl_big got %h want 00", Dout); end
    load_a(8'h80); load_b(8'h08);
    run_op(3'b101, 1'b0, lat, bc);
    checks++; if (Dout !== 8'h00) begin failures++; $display("FAIL shr_width got %h want 00", Dout); end
    load_b(8'h07);
    run_op(3'b101, 1'b0, lat, bc);
    checks++; if (Dout !== 8'h01) begin failures++; $display("FAIL shr_max got %h want 01", Dout); end
    run_op(3'b110, 1'b0, lat, bc);
    checks++; if (lat !== 1) begin failures++; $display("FAIL rsv_latency got %0d want 1", lat); end
    checks++; if ({Dout, DoutH, CARRY} !== 17'h0) begin
      failures++; $display("FAIL rsv_result got %h want 00000", {Dout, DoutH, CARRY});
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    load_a(8'h02); load_b(8'h03);
    // Load and START in the same cycle: the op must see the old A.
    Din = 8'h10; An = 1'b0; OP = 3'b000; START = 1'b1;
    @(posedge CLK); #1;
    An = 1'b1; START = 1'b0;
    @(posedge CLK); #1;
    checks++; if ({DONE, Dout} !== 9'h105) begin
      failures++; $display("FAIL start_with_load got %h want 105", {DONE, Dout});
    end
    run_op(3'b000, 1'b0, lat, bc);
    checks++; if (Dout !== 8'h13) begin failures++; $display("FAIL post_load_sum got %h want 13", Dout); end
  endtask

  task automatic test_abort();
    int lat, bc;
    bit seen;
    load_a(8'h05); load_b(8'h06);
    run_op(3'b000, 1'b0, lat, bc);
    checks++; if (Dout !== 8'h0B) begin failures++; $display("FAIL pre_abort_sum got %h want 0b", Dout); end
    @(posedge CLK); #1;
    OP = 3'b010; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL abort_busy_before got %b want 1", BUSY); end
    RST = 1'b1;
    #1;
    checks++; if ({BUSY, DONE, Dout} !== 10'h000) begin
      failures++; $display("FAIL abort_async got %h want 000", {BUSY, DONE, Dout});
    end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (DONE) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got %b want 0", seen); end
    load_a(8'h03); load_b(8'h04);
    run_op(3'b000, 1'b0, lat, bc);
    checks++; if (Dout !== 8'h07) begin failures++; $display("FAIL post_abort_sum got %h want 07", Dout); end
  endtask

`ifdef SEQ_ALU_SIGNED_EN
  task automatic test_signed();
    int lat, bc;
    sgn = 1'b1;
    load_a(8'hF9); load_b(8'h02);
    run_op(3'b011, 1'b0, lat, bc);
    checks++; if ({Dout, DoutH} !== 16'hFDFF) begin
      failures++; $display("FAIL sdiv got %h want fdff", {Dout, DoutH});
    end
    load_a(8'hFE); load_b(8'h03);
    run_op(3'b010, 1'b0, lat, bc);
    checks++; if ({DoutH, Dout} !== 16'hFFFA) begin
      failures++; $display("FAIL smul got %h want fffa", {DoutH, Dout});
    end
    sgn = 1'b0;
  endtask
`endif

  initial begin
    RST = 1'b1; An = 1'b1; Bn = 1'b1; START = 1'b0; Din = '0; OP = 3'b000;
`ifdef SEQ_ALU_SIGNED_EN
    sgn = 1'b0;
`endif
    test_reset();
    test_sum_sub();
    test_mul();
    test_div();
    test_shift();
    test_back_to_back();
    test_abort();
`ifdef SEQ_ALU_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, clocked successor to the 8-bit CPU's combinational ALU.
- Holds operand registers A and B, loaded from the shared data bus Din through active-low load strobes.
- Single-cycle ops: add, subtract, shift.
- Multi-cycle ops: iterative shift-add multiply and restoring divide.
- START/BUSY/DONE handshake lets the control unit stall on long ops.

Parameters:
WIDTH, 8, datapath width in bits (>=4); the cycle counter is $clog2(WIDTH)+1 bits.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
An  input  1  active-low: load A from Din at the clock edge.
Bn  input  1  active-low: load B from Din at the clock edge.
Din  input  WIDTH  operand data bus.
OP  input  3  opcode, sampled with START.
START  input  1  one-cycle request to begin OP on the current A/B.
BUSY  output  1  high while a multi-cycle op is in progress.
DONE  output  1  one-cycle pulse when Dout/DoutH/flags become valid.
Dout  output  WIDTH  primary result.
DoutH  output  WIDTH  product high half / remainder; 0 for other ops.
CARRY  output  1  carry out of SUM; borrow out of SUB; 0 otherwise.
DIVZ  output  1  divide-by-zero flag for the last DIV.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: A, B, Dout, DoutH, CARRY, DIVZ, BUSY and DONE are all 0; FSM returns to IDLE. A reset mid-operation aborts the op and leaves no DONE pulse.
- Opcodes:
  - 000 SUM: A+B.
  - 001 SUB: A-B, two's complement.
  - 010 MUL: A*B, 2*WIDTH-bit product; DoutH:Dout = {hi, lo}.
  - 011 DIV: Dout = A/B, DoutH = A%B.
  - 100 SHL: A<<B.
  - 101 SHR: A>>B, logical.
  - 110 and 111 reserved: single-cycle; Dout, DoutH and CARRY all 0.
- Shift amount: the full B value; if B>=WIDTH the result is 0.
- Operand loads: An/Bn take effect only in IDLE and are ignored while BUSY. If An and Bn are both low, A and B both load Din.
- START is honoured only in IDLE with no DONE pulse pending; it is ignored while BUSY. START in the same cycle as a load uses the pre-load A/B.
- FSM states: IDLE, ITER, FINISH.
  - IDLE -> FINISH for single-cycle ops and for DIV with B==0.
  - IDLE -> ITER for MUL, and for DIV with B!=0; iteration counter loaded with WIDTH.
  - ITER: one partial-product or trial-subtract step per cycle; counter decrements; -> FINISH when the counter reaches 1.
  - FINISH: outputs registered, DONE=1 for one cycle, -> IDLE.
- Latency, START sampled at edge k:
  - Single-cycle ops: DONE and results at edge k+1.
  - MUL/DIV: DONE at edge k+WIDTH+1.
  - BUSY is high from edge k+1 until the DONE edge, exclusive of it.
- Result persistence: Dout, DoutH and the flags hold their value until the next DONE.
- Divide by zero: DIVZ=1, Dout=all ones, DoutH=A, single-cycle. DIVZ is cleared by any later DONE.

Optional Feature:
SEQ_ALU_SIGNED_EN.
- Defined:
  - Adds input port SIGNED (1 bit), sampled with START.
  - When SIGNED=1: MUL is two's-complement. DIV truncates toward zero and the remainder takes the sign of the dividend. SHR is arithmetic. CARRY reports signed overflow for SUM/SUB.
  - Most-negative / -1 returns quotient = most-negative, remainder 0, DIVZ=0.
  - Latency is unchanged; sign fix-up is done in FINISH.
- Undefined: SIGNED port is absent; all ops are unsigned.

Decomposition:
- Package seq_alu_pkg holds:
  - the opcode enum (OP_SUM..OP_SHR, OP_RSV);
  - the state enum (S_IDLE, S_ITER, S_FINISH);
  - localparam helpers for counter width.
- One natural sub-module, seq_alu_muldiv: the iterative MUL/DIV core with its own accumulator, counter and step logic. It is started and stopped by the top FSM; the top keeps operand registers, single-cycle ops and output registers.

Test Plan (WIDTH=8):
- An low with Din=0x07, then Bn low with Din=0x06, START OP=SUM -> one cycle later DONE=1, Dout=0x0D, CARRY=0; then SUB with A=0x04, B=0x05 -> Dout=0xFF, CARRY=1.
- A=0xFF, B=0xFF, START MUL -> BUSY high for 8 cycles, DONE at edge k+9, DoutH=0xFE, Dout=0x01; pulse An low with Din=0x00 while BUSY -> A unchanged; re-run MUL -> same result.
- A=0x64, B=0x07, START DIV -> DONE at k+9, Dout=0x0E, DoutH=0x02, DIVZ=0; then B=0x00, DIV -> DONE at k+1, DIVZ=1, Dout=0xFF, DoutH=0x64.
- A=0x08, B=0x02: SHR -> 0x02, SHL -> 0x20; B=0x09, SHL -> 0x00; OP=110 -> Dout=0x00, DONE at k+1.
- Start MUL, assert RST at cycle 4 -> BUSY=0, Dout=0 immediately, no DONE; after release, SUM of 0x03+0x04 -> 0x07.
- SEQ_ALU_SIGNED_EN, SIGNED=1: A=0xF9 (-7), B=0x02, DIV -> Dout=0xFD, DoutH=0xFF; MUL A=0xFE, B=0x03 -> DoutH:Dout=0xFFFA.
